// File: rtl/video_int_gen.sv
// ---------------------------------------------------------------------------
// video_int_gen -- raster position counters and Z80 INT request generator.
//
// Tracks the horizontal position (hcnt, in hc_tick units) and the raster
// line (vcnt). When the horizontal position reaches hint_beg, a line
// interrupt and/or a frame interrupt (the latter only on line vint_beg) is
// raised. The result is an active-low INT window of INT_LEN clocks. The
// window can be cut short by an acknowledge, and a new match restarts it.
//
// Parameters
//   INT_LEN      INT request duration in clk cycles (1..63)
// Ports
//   clk          system clock, rising edge
//   resn         asynchronous active-low reset
//   line_start   one-cycle pulse at the start of each raster line
//   frame_start  one-cycle pulse at the start of raster line 0
//   hc_tick      one-cycle pulse per horizontal interrupt-position unit
//   hint_beg     horizontal interrupt position (hc_tick units)
//   vint_beg     vertical interrupt line
//   intmask      bit0 = frame interrupt enable, bit1 = line interrupt enable
//   intack       one-cycle Z80 interrupt acknowledge pulse
//   hcnt         horizontal position counter
//   vcnt         line counter
//   int_start    one-cycle pulse after a frame-interrupt match
//   int_n        active-low INT request
//   int_frame    frame interrupt pending
//   int_line     line interrupt pending
// ---------------------------------------------------------------------------
module video_int_gen #(
  parameter int INT_LEN = 32
) (
  input  logic       clk,
  input  logic       resn,
  input  logic       line_start,
  input  logic       frame_start,
  input  logic       hc_tick,
  input  logic [7:0] hint_beg,
  input  logic [8:0] vint_beg,
  input  logic [1:0] intmask,
  input  logic       intack,
  output logic [7:0] hcnt,
  output logic [8:0] vcnt,
  output logic       int_start,
  output logic       int_n,
  output logic       int_frame,
  output logic       int_line
);

  localparam logic [5:0] CNT_LOAD = 6'(INT_LEN - 1);

  typedef enum logic {IDLE, ASSERT} state_t;

  state_t     state_reg, state_next;
  logic [5:0] cnt_reg, cnt_next;
  logic       int_frame_next, int_line_next;
  logic [7:0] hcnt_next, hcnt_inc;
  logic [8:0] vcnt_next;
  logic       hmatch, fmatch, lmatch, any_match;

  // Position counters: line_start/frame_start restart, ticks advance.
  assign hcnt_inc = hcnt + 8'd1;

  always_comb begin
    hcnt_next = hcnt;
    if (line_start)
      hcnt_next = 8'd0;
    else if (hc_tick)
      hcnt_next = hcnt_inc;
  end

  always_comb begin
    vcnt_next = vcnt;
    if (frame_start)
      vcnt_next = 9'd0;
    else if (line_start)
      vcnt_next = vcnt + 9'd1;
  end

  // The match fires in the cycle in which hcnt is about to become hint_beg.
  // Position 0 is never reached by a tick inside a line, so it is taken
  // from line_start instead.
  assign hmatch    = (hc_tick && (hcnt_inc == hint_beg)) ||
                     (line_start && (hint_beg == 8'd0));
  // The frame compare uses the line number as it will be after this edge.
  assign fmatch    = hmatch && (vcnt_next == vint_beg) && intmask[0];
  assign lmatch    = hmatch && intmask[1];
  assign any_match = fmatch || lmatch;

  // INT window FSM, next-state logic.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    int_frame_next = int_frame;
    int_line_next  = int_line;
    case (state_reg)
      IDLE: begin
        // intack is deliberately ignored here.
        if (any_match) begin
          state_next     = ASSERT;
          cnt_next       = CNT_LOAD;
          int_frame_next = fmatch;
          int_line_next  = lmatch;
        end
      end
      ASSERT: begin
        if (any_match) begin
          cnt_next = CNT_LOAD;
          if (intack || (cnt_reg == 6'd0)) begin
            // The old request ends this cycle. Only the new cause survives.
            int_frame_next = fmatch;
            int_line_next  = lmatch;
          end else begin
            int_frame_next = int_frame | fmatch;
            int_line_next  = int_line | lmatch;
          end
        end else if (intack || (cnt_reg == 6'd0)) begin
          state_next     = IDLE;
          cnt_next       = 6'd0;
          int_frame_next = 1'b0;
          int_line_next  = 1'b0;
        end else begin
          cnt_next = cnt_reg - 6'd1;
        end
      end
      default: begin
        state_next     = IDLE;
        cnt_next       = 6'd0;
        int_frame_next = 1'b0;
        int_line_next  = 1'b0;
      end
    endcase
  end

  // The mask is applied only to new matches. It never clears pending flags.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state_reg <= IDLE;
      cnt_reg   <= 6'd0;
      hcnt      <= 8'd0;
      vcnt      <= 9'd0;
      int_start <= 1'b0;
      int_n     <= 1'b1;
      int_frame <= 1'b0;
      int_line  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hcnt      <= hcnt_next;
      vcnt      <= vcnt_next;
      int_start <= fmatch;
      // int_n is registered from the next state, so it tracks ASSERT
      // exactly and has no combinational path from the inputs.
      int_n     <= (state_next != ASSERT);
      int_frame <= int_frame_next;
      int_line  <= int_line_next;
    end
  end

endmodule

// File: tb/tb_video_int_gen.sv
// ---------------------------------------------------------------------------
// tb_video_int_gen -- scoreboard bench for video_int_gen.
// The stimulus process queues the expected values (tagged with the cycle in
// which they must hold). A monitor process samples on the falling edge and
// compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_video_int_gen;

  logic       clk = 1'b0;
  logic       resn;
  logic       line_start, frame_start, hc_tick, intack;
  logic [7:0] hint_beg;
  logic [8:0] vint_beg;
  logic [1:0] intmask;
  logic [7:0] hcnt;
  logic [8:0] vcnt;
  logic       int_start, int_n, int_frame, int_line;

  video_int_gen #(.INT_LEN(32)) dut (
    .clk(clk), .resn(resn), .line_start(line_start), .frame_start(frame_start),
    .hc_tick(hc_tick), .hint_beg(hint_beg), .vint_beg(vint_beg),
    .intmask(intmask), .intack(intack), .hcnt(hcnt), .vcnt(vcnt),
    .int_start(int_start), .int_n(int_n), .int_frame(int_frame),
    .int_line(int_line)
  );

  always #5 clk = ~clk;

  localparam int F_HCNT = 0, F_VCNT = 1, F_START = 2, F_INTN = 3, F_FRAME = 4, F_LINE = 5;

  typedef struct {
    string name;
    int    cyc;
    int    fld;
    int    val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation that is due this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      int   act;
      e = q.pop_front();
      case (e.fld)
        F_HCNT:  act = int'(hcnt);
        F_VCNT:  act = int'(vcnt);
        F_START: act = int'(int_start);
        F_INTN:  act = int'(int_n);
        F_FRAME: act = int'(int_frame);
        default: act = int'(int_line);
      endcase
      checks++;
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
      end else if (act != e.val) begin
        failures++;
        $display("FAIL %s: cycle %0d got %0d expected %0d", e.name, cyc, act, e.val);
      end else begin
        $display("ok   %s: cycle %0d value %0d", e.name, cyc, act);
      end
    end
  end

  task automatic chk(input string nm, input int f, input int v);
    exp_t e;
    e.name = nm; e.cyc = cyc; e.fld = f; e.val = v;
    q.push_back(e);
  endtask

  // Advance one clock. Pulse inputs last exactly one cycle.
  task automatic step();
    @(posedge clk);
    #1;
    line_start = 1'b0; frame_start = 1'b0; hc_tick = 1'b0; intack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic goto_line(input int v);
    frame_start = 1'b1; line_start = 1'b1; step();
    for (int i = 0; i < v; i++) begin
      line_start = 1'b1; step();
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      hc_tick = 1'b1; step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resn = 1'b0; line_start = 1'b0; frame_start = 1'b0; hc_tick = 1'b0;
    intack = 1'b0; hint_beg = 8'd3; vint_beg = 9'd100; intmask = 2'b00;

    // Reset state, with activity on the inputs.
    hc_tick = 1'b1; line_start = 1'b1; step();
    chk("rst_hcnt", F_HCNT, 0); chk("rst_vcnt", F_VCNT, 0);
    chk("rst_start", F_START, 0); chk("rst_intn", F_INTN, 1);
    chk("rst_frame", F_FRAME, 0); chk("rst_line", F_LINE, 0);
    resn = 1'b1;
    idle(2);

    // Frame interrupt: line 100, third tick.
    intmask = 2'b01; hint_beg = 8'd3; vint_beg = 9'd100;
    goto_line(100);
    ticks(3);                                       // window cycle 1
    chk("frm_start1", F_START, 1); chk("frm_intn1", F_INTN, 0);
    chk("frm_flag1", F_FRAME, 1); chk("frm_line1", F_LINE, 0);
    chk("frm_hcnt", F_HCNT, 3); chk("frm_vcnt", F_VCNT, 100);
    intmask = 2'b00;                                // pending flag must survive
    idle(1);
    chk("frm_start2", F_START, 0);
    idle(30);                                       // cycle 32
    chk("frm_intn32", F_INTN, 0); chk("frm_flag32", F_FRAME, 1);
    idle(1);                                        // cycle 33
    chk("frm_intn33", F_INTN, 1); chk("frm_flag33", F_FRAME, 0);
    chk("frm_line33", F_LINE, 0);

    // Line interrupt on every line_start with hint_beg = 0.
    intmask = 2'b10; hint_beg = 8'd0;
    for (int l = 0; l < 2; l++) begin
      line_start = 1'b1; step();
      chk("lin_intn1", F_INTN, 0); chk("lin_flag1", F_LINE, 1);
      chk("lin_frame1", F_FRAME, 0); chk("lin_start1", F_START, 0);
      idle(31);
      chk("lin_intn32", F_INTN, 0); chk("lin_start32", F_START, 0);
      idle(1);
      chk("lin_intn33", F_INTN, 1); chk("lin_flag33", F_LINE, 0);
    end

    // Acknowledge in cycle 5 of a frame window, then in IDLE.
    intmask = 2'b01; hint_beg = 8'd3; vint_beg = 9'd100;
    goto_line(100);
    ticks(3);
    chk("ack_intn1", F_INTN, 0);
    idle(4);
    chk("ack_intn5", F_INTN, 0); chk("ack_frame5", F_FRAME, 1);
    intack = 1'b1; step();
    chk("ack_intn6", F_INTN, 1); chk("ack_frame6", F_FRAME, 0);
    idle(3);
    intack = 1'b1; step();
    chk("ackidle_intn", F_INTN, 1); chk("ackidle_frame", F_FRAME, 0);
    chk("ackidle_line", F_LINE, 0);

    // Retrigger: line match inside a frame window extends it.
    goto_line(100);
    ticks(3);
    chk("rtg_frame1", F_FRAME, 1); chk("rtg_line1", F_LINE, 0);
    idle(8);
    intmask = 2'b11;
    line_start = 1'b1; step();                      // line 101, hcnt 0
    ticks(3);                                       // new window cycle 1
    chk("rtg_intn_new", F_INTN, 0); chk("rtg_frame_new", F_FRAME, 1);
    chk("rtg_line_new", F_LINE, 1); chk("rtg_start_new", F_START, 0);
    idle(20);
    chk("rtg_intn_old_end", F_INTN, 0);
    idle(11);
    chk("rtg_intn32", F_INTN, 0); chk("rtg_frame32", F_FRAME, 1);
    chk("rtg_line32", F_LINE, 1);
    idle(1);
    chk("rtg_intn33", F_INTN, 1); chk("rtg_frame33", F_FRAME, 0);
    chk("rtg_line33", F_LINE, 0);

    // Collision: a line match in the same cycle as intack.
    intmask = 2'b01; hint_beg = 8'd0; vint_beg = 9'd5;
    goto_line(5);
    chk("col_frame1", F_FRAME, 1); chk("col_start1", F_START, 1);
    idle(4);
    intmask = 2'b10; intack = 1'b1; line_start = 1'b1; step();
    chk("col_intn", F_INTN, 0); chk("col_frame", F_FRAME, 0);
    chk("col_line", F_LINE, 1);
    idle(31);
    chk("col_intn32", F_INTN, 0);
    idle(1);
    chk("col_intn33", F_INTN, 1);

    // Counter wrap.
    intmask = 2'b00;
    goto_line(511);
    chk("wrap_v511", F_VCNT, 511);
    line_start = 1'b1; step();
    chk("wrap_v0", F_VCNT, 0);
    line_start = 1'b1; step();
    ticks(255);
    chk("wrap_h255", F_HCNT, 255);
    ticks(1);
    chk("wrap_h0", F_HCNT, 0);
    line_start = 1'b1; step();
    ticks(5);
    chk("pre_fs_h5", F_HCNT, 5); chk("pre_fs_v2", F_VCNT, 2);
    frame_start = 1'b1; line_start = 1'b1; step();
    chk("fs_ls_v0", F_VCNT, 0); chk("fs_ls_h0", F_HCNT, 0);

    // Asynchronous reset in the middle of a window.
    intmask = 2'b01; hint_beg = 8'd3; vint_beg = 9'd100;
    goto_line(100);
    ticks(3);
    chk("ar_intn1", F_INTN, 0);
    idle(8);
    #2 resn = 1'b0;                                 // mid-cycle, before negedge
    chk("ar_intn", F_INTN, 1); chk("ar_frame", F_FRAME, 0);
    chk("ar_line", F_LINE, 0); chk("ar_hcnt", F_HCNT, 0);
    chk("ar_vcnt", F_VCNT, 0);
    step(); step();
    #3 resn = 1'b1;
    goto_line(100);
    ticks(3);
    chk("ar2_intn1", F_INTN, 0); chk("ar2_frame1", F_FRAME, 1);
    idle(31);
    chk("ar2_intn32", F_INTN, 0);
    idle(1);
    chk("ar2_intn33", F_INTN, 1);

    idle(3);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_int_gen.md
VIDEO_INT_GEN -- requirements
Module: video_int_gen

Interface
REQ-001 SHALL have parameter INT_LEN, default 32, meaning INT request duration in clk cycles (legal range 1..63).
REQ-002 SHALL have port clk, input, 1: system clock; all state changes on rising edge.
REQ-003 SHALL have port resn, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port line_start, input, 1: one-cycle pulse at the start of each raster line.
REQ-005 SHALL have port frame_start, input, 1: one-cycle pulse at the start of raster line 0.
REQ-006 SHALL have port hc_tick, input, 1: one-cycle pulse per horizontal interrupt-position unit.
REQ-007 SHALL have port hint_beg, input, 8: horizontal interrupt position, in hc_tick units.
REQ-008 SHALL have port vint_beg, input, 9: vertical interrupt line.
REQ-009 SHALL have port intmask, input, 2: bit0 enables the frame interrupt, bit1 enables the line interrupt.
REQ-010 SHALL have port intack, input, 1: one-cycle pulse on a Z80 interrupt acknowledge.
REQ-011 SHALL have port hcnt, output, 8: horizontal position counter.
REQ-012 SHALL have port vcnt, output, 9: line counter.
REQ-013 SHALL have port int_start, output, 1: one-cycle pulse on a frame-interrupt match; video_ports consumes it to advance vint_beg.
REQ-014 SHALL have port int_n, output, 1: active-low Z80 INT request.
REQ-015 SHALL have port int_frame, output, 1: frame-interrupt pending flag.
REQ-016 SHALL have port int_line, output, 1: line-interrupt pending flag.

Function
REQ-017 SHALL update hcnt as follows: cleared to 0 on line_start; otherwise incremented by 1 on hc_tick, wrapping 255->0.
REQ-018 SHALL update vcnt as follows: cleared to 0 on frame_start; otherwise incremented by 1 on line_start, wrapping 511->0; frame_start takes priority over line_start in the same cycle.
REQ-019 SHALL evaluate the position match hmatch = hc_tick AND (hcnt+1 == hint_beg), computed on 8 bits, so a match fires in the cycle that hcnt becomes hint_beg.
REQ-020 SHALL also treat hint_beg == 0 as a match, on line_start.
REQ-021 SHALL define fmatch = hmatch AND (vcnt == vint_beg) AND intmask[0], where vcnt is the value after this cycle's update.
REQ-022 SHALL define lmatch = hmatch AND intmask[1].
REQ-023 SHALL register int_start = fmatch, giving a one-cycle pulse with 1-cycle latency from the match cycle.
REQ-024 SHALL implement a two-state FSM, IDLE and ASSERT, with a 6-bit down-counter cnt.
REQ-025 SHALL take IDLE->ASSERT when fmatch or lmatch occurs: cnt loads INT_LEN-1, and int_frame / int_line set per the match type.
REQ-026 SHALL, in ASSERT, decrement cnt each cycle; at cnt==0 go to IDLE and clear both flags.
REQ-027 SHALL, in ASSERT on intack, go to IDLE and clear both flags next cycle.
REQ-028 SHALL, on a new match during ASSERT, reload cnt to INT_LEN-1 and OR the new flag into the existing flags.
REQ-029 SHALL give a match priority over a simultaneous intack or cnt==0, so the state stays ASSERT and only the new match's flag remains set.
REQ-030 SHALL drive int_n = 0 exactly while in ASSERT, registered with no combinational path from inputs.
REQ-031 SHALL ignore intack in IDLE.
REQ-032 SHALL not clear already-pending flags when intmask bits are cleared; the mask gates new matches only.

Reset
REQ-033 SHALL, while resn==0 asynchronously: hcnt=0, vcnt=0, int_start=0, int_n=1, int_frame=0, int_line=0, cnt=0, state IDLE.
REQ-034 SHALL, on resn deassertion mid-assertion, leave no residual INT; the first match after release behaves as from IDLE.

Verification
REQ-035 SHALL verify frame interrupt: intmask=01, vint_beg=100, hint_beg=3; run to line 100, 3rd hc_tick -> int_start single pulse; int_n low exactly 32 cycles; int_frame=1 then 0; int_line stays 0.
REQ-036 SHALL verify line interrupt: intmask=10, hint_beg=0 -> int_line pulse window each line_start; 0 frame pulses; int_start never asserted.
REQ-037 SHALL verify acknowledge: frame INT asserted, intack at cycle 5 of window -> int_n=1 and int_frame=0 on cycle 6; later intack in IDLE -> no effect.
REQ-038 SHALL verify retrigger and collision: intmask=11, line match during ASSERT -> window extends to 32 cycles from the new match, both flags=1; a match coincident with intack -> int_n stays 0.
REQ-039 SHALL verify wrap: 512 line_start without frame_start -> vcnt 511->0; 256 hc_tick in a line -> hcnt 255->0; frame_start with line_start in the same cycle -> vcnt=0, hcnt=0.
REQ-040 SHALL verify async reset: resn pulled low mid-window, not clock-aligned -> int_n=1, flags=0, counters=0 immediately; next match -> full 32-cycle window.
